// File: rtl/mmio_hub_pkg.sv
// Shared constants for the memory-mapped peripheral hub: register offsets,
// timer control bit positions and the size of the register window.
package mmio_hub_pkg;

    // The hub decodes a 64-byte window; the low address bits select a register.
    localparam int WINDOW_BYTES  = 64;
    localparam int WIN_ADDR_BITS = $clog2(WINDOW_BYTES);

    // Byte offsets of the registers inside the window (word aligned).
    localparam logic [WIN_ADDR_BITS-1:0] OFF_HEX   = 6'h00;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_LEDR  = 6'h04;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_KEY   = 6'h10;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_SW    = 6'h14;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_KCAP  = 6'h18;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_KMASK = 6'h1C;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_TCNT  = 6'h20;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_TLIM  = 6'h24;
    localparam logic [WIN_ADDR_BITS-1:0] OFF_TCTL  = 6'h28;

    // Bit positions inside the timer control register.
    localparam int TCTL_EN  = 0;
    localparam int TCTL_IE  = 1;
    localparam int TCTL_RDY = 2;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to 7-segment glyph, active-low, segment order {g,f,e,d,c,b,a}.
module seg7_decoder (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Pure lookup of the glyph for digits 0-F.
    always_comb begin
        segments = 7'b1111111;
        case (digit)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            4'hF: segments = 7'b0001110;
            default: segments = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped hub for keys, switches, LEDs, 7-segment digits and an
// interval timer, with sticky key-press capture and a level interrupt.
//
// Bus handshake: req is a one-cycle strobe (qualified by we for writes) that
// is only honoured when hit is high. Every honoured request produces exactly
// one ack pulse in the following cycle, with rdata valid during that pulse
// (rdata is 0 otherwise and for writes). There is no back-pressure, so a new
// request may be issued every cycle.
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter int               DBITS      = 32,
    parameter logic [DBITS-1:0] BASE_ADDR  = 32'hF0000000,
    parameter int               KEY_BITS   = 4,
    parameter int               SW_BITS    = 10,
    parameter int               LEDR_BITS  = 10,
    parameter int               HEX_DIGITS = 4,
    parameter int               TIMER_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [DBITS-1:0]        addr,
    input  logic [DBITS-1:0]        wdata,
    output logic                    hit,
    output logic                    ack,
    output logic [DBITS-1:0]        rdata,
    input  logic [KEY_BITS-1:0]     KEY,
    input  logic [SW_BITS-1:0]      SW,
    output logic [LEDR_BITS-1:0]    LEDR,
    output logic [7*HEX_DIGITS-1:0] HEX,
    output logic                    irq
);

    localparam int HEX_BITS = 4 * HEX_DIGITS;

    logic [WIN_ADDR_BITS-1:0] offset;
    logic                     access;
    logic                     wrEn;
    logic                     unusedAddrBits;

    logic [KEY_BITS-1:0]   keySync1, keySync2, keyPrev, keyRise;
    logic [SW_BITS-1:0]    swSync1, swSync2;
    logic [HEX_BITS-1:0]   hexReg;
    logic [LEDR_BITS-1:0]  ledrReg;
    logic [KEY_BITS-1:0]   kcap, kmask;
    logic [TIMER_BITS-1:0] tcnt, tlim, tcntInc;
    logic                  tEn, tIe, tRdy;
    logic                  tWrap;
    logic [DBITS-1:0]      readData;

    // Byte lanes inside a word are not distinguished.
    assign offset         = {addr[WIN_ADDR_BITS-1:2], 2'b00};
    assign unusedAddrBits = ^addr[1:0];

    assign hit    = (addr[DBITS-1:WIN_ADDR_BITS] == BASE_ADDR[DBITS-1:WIN_ADDR_BITS]);
    assign access = req & hit;
    assign wrEn   = access & we;

    assign keyRise = keySync2 & ~keyPrev;
    assign tcntInc = tcnt + TIMER_BITS'(1);
    assign tWrap   = tEn & (tcnt == tlim);

    assign LEDR = ledrReg;
    assign irq  = (|(kcap & kmask)) | (tRdy & tIe);

    // Two-flop synchronisers; keys are inverted on entry so 1 means pressed
    // and the all-zero reset state reads as "nothing pressed".
    always_ff @(posedge clk) begin
        if (!reset) begin
            keySync1 <= '0;
            keySync2 <= '0;
            keyPrev  <= '0;
            swSync1  <= '0;
            swSync2  <= '0;
        end else begin
            keySync1 <= ~KEY;
            keySync2 <= keySync1;
            keyPrev  <= keySync2;
            swSync1  <= SW;
            swSync2  <= swSync1;
        end
    end

    // Plain read/write registers: digits, LEDs and the key interrupt mask.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hexReg  <= '0;
            ledrReg <= '0;
            kmask   <= '0;
        end else if (wrEn) begin
            if (offset == OFF_HEX)   hexReg  <= wdata[HEX_BITS-1:0];
            if (offset == OFF_LEDR)  ledrReg <= wdata[LEDR_BITS-1:0];
            if (offset == OFF_KMASK) kmask   <= wdata[KEY_BITS-1:0];
        end
    end

    // Sticky press capture; a new press edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kcap <= '0;
        end else if (wrEn && offset == OFF_KCAP) begin
            kcap <= (kcap & ~wdata[KEY_BITS-1:0]) | keyRise;
        end else begin
            kcap <= kcap | keyRise;
        end
    end

    // Interval timer: count up to the limit, wrap to 0 and flag RDY.
    // A bus write to the count replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt <= '0;
            tlim <= '1;
            tEn  <= 1'b0;
            tIe  <= 1'b0;
            tRdy <= 1'b0;
        end else begin
            if (wrEn && offset == OFF_TCNT) begin
                tcnt <= wdata[TIMER_BITS-1:0];
            end else if (tEn) begin
                tcnt <= tWrap ? '0 : tcntInc;
            end
            if (wrEn && offset == OFF_TLIM) begin
                tlim <= wdata[TIMER_BITS-1:0];
            end
            if (wrEn && offset == OFF_TCTL) begin
                tEn  <= wdata[TCTL_EN];
                tIe  <= wdata[TCTL_IE];
                tRdy <= (tRdy & ~wdata[TCTL_RDY]) | tWrap;
            end else begin
                tRdy <= tRdy | tWrap;
            end
        end
    end

    // Read multiplexer; unmapped offsets and unused high bits read as 0.
    always_comb begin
        readData = '0;
        case (offset)
            OFF_HEX:   readData[HEX_BITS-1:0]   = hexReg;
            OFF_LEDR:  readData[LEDR_BITS-1:0]  = ledrReg;
            OFF_KEY:   readData[KEY_BITS-1:0]   = keySync2;
            OFF_SW:    readData[SW_BITS-1:0]    = swSync2;
            OFF_KCAP:  readData[KEY_BITS-1:0]   = kcap;
            OFF_KMASK: readData[KEY_BITS-1:0]   = kmask;
            OFF_TCNT:  readData[TIMER_BITS-1:0] = tcnt;
            OFF_TLIM:  readData[TIMER_BITS-1:0] = tlim;
            OFF_TCTL:  readData[2:0]            = {tRdy, tIe, tEn};
            default:   readData = '0;
        endcase
    end

    // Registered response: one ack per honoured request, reset drops it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= access;
            rdata <= (access && !we) ? readData : '0;
        end
    end

    // One glyph decoder per digit.
    for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_digit
        seg7_decoder u_dec (
            .digit    (hexReg[4*i +: 4]),
            .segments (HEX[7*i +: 7])
        );
    end

endmodule
